// File: rtl/bcd_time_display.sv
// ============================================================================
// bcd_time_display
// Scans a packed MM:SS BCD time word onto a 4-digit common-anode display,
// with a per-frame snapshot and a blink alarm at 00:00.
// Optional macro: LEADING_ZERO_BLANK_EN (blanks a zero minutes-tens digit).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_time_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_time,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick;
  logic [1:0]    next_idx;
  logic          frame_start;
  logic [15:0]   eff_time;
  logic [3:0]    nibble;
  logic          alarm_blank;
  logic          lead_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick        = (pre == PRE_LAST);
  assign next_idx    = idx + 2'd1;
  assign frame_start = tick && (idx == 2'd3);
  // Digit 0 of a new frame must see the word being captured this very tick.
  assign eff_time    = frame_start ? bcd_time : snap;

  always_comb begin
    nibble = 4'd0;
    case (next_idx)
      2'd0: nibble = eff_time[3:0];
      2'd1: nibble = eff_time[7:4];
      2'd2: nibble = eff_time[11:8];
      2'd3: nibble = eff_time[15:12];
      default: nibble = 4'd0;
    endcase
  end

  assign alarm_blank = (eff_time == 16'h0000) && blink_phase;

`ifdef LEADING_ZERO_BLANK_EN
  assign lead_blank = (next_idx == 2'd3) && (nibble == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre         <= '0;
      idx         <= 2'd3;
      snap        <= 16'h0000;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (tick) begin
        pre <= '0;
      end else begin
        pre <= pre + PW'(1);
      end

      if (tick) begin
        idx <= next_idx;
        if (frame_start) begin
          snap <= bcd_time;
        end

        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end

        if (alarm_blank) begin
          an  <= 4'b1111;
          seg <= SEG_BLANK;
          dp  <= 1'b1;
        end else if (lead_blank) begin
          an  <= 4'b1111;
          seg <= SEG_BLANK;
          dp  <= 1'b1;
        end else begin
          an  <= ~(4'b0001 << next_idx);
          seg <= decode(nibble);
          dp  <= (next_idx != 2'd2);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_display.sv
// Scoreboard bench for bcd_time_display (SCAN_DIV=4, BLINK_TICKS=2).
`default_nettype none

module tb_bcd_time_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_time = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t  q[$];
  string tagq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always #5 clk = ~clk;

  bcd_time_display #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_time(bcd_time),
    .an(an), .seg(seg), .dp(dp)
  );

  // Monitor: every 4th clock after reset release is a scan tick.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      if ((cyc % 4 == 0) && (q.size() > 0)) begin
        exp_t  e;
        string t;
        #1;
        e = q.pop_front();
        t = tagq.pop_front();
        total = total + 1;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          bad = bad + 1;
          $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   t, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input string t);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d;
    q.push_back(e);
    tagq.push_back(t);
  endtask

  task automatic drain(input string t);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s timeout: %0d expected ticks never observed, want 0", t, q.size());
      q.delete();
      tagq.delete();
    end
  endtask

  task automatic do_reset(input logic [15:0] v);
    @(negedge clk);
    rst_n = 1'b0;
    bcd_time = v;
    repeat (2) @(negedge clk);
    total = total + 1;
    if (an !== 4'b1111 || seg !== SB || dp !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL reset: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
               an, seg, dp);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, want completion");
    $fatal(1);
  end

  initial begin
    // Basic scan of 12:34
    do_reset(16'h1234);
    push(4'b1110, S4, 1'b1, "scan d0");
    push(4'b1101, S3, 1'b1, "scan d1");
    push(4'b1011, S2, 1'b0, "scan d2");
    push(4'b0111, S1, 1'b1, "scan d3");
    drain("scan");

    // Frame tearing: change word during the digit 1 slot
    do_reset(16'h0959);
    push(4'b1110, S9, 1'b1, "tear d0");
    push(4'b1101, S5, 1'b1, "tear d1");
    drain("tear a");
    bcd_time = 16'h1000;
    push(4'b1011, S9, 1'b0, "tear old d2");
    push(4'b0111, S0, 1'b1, "tear old d3");
    push(4'b1110, S0, 1'b1, "tear new d0");
    push(4'b1101, S0, 1'b1, "tear new d1");
    push(4'b1011, S0, 1'b0, "tear new d2");
    push(4'b0111, S1, 1'b1, "tear new d3");
    drain("tear b");

    // Invalid digit shows a dash
    do_reset(16'h00A7);
    push(4'b1110, S7, 1'b1, "inv d0");
    push(4'b1101, SD, 1'b1, "inv d1");
    push(4'b1011, S0, 1'b0, "inv d2");
`ifdef LEADING_ZERO_BLANK_EN
    push(4'b1111, SB, 1'b1, "inv d3");
`else
    push(4'b0111, S0, 1'b1, "inv d3");
`endif
    drain("inv");

    // Zero alarm: two normal ticks, two blank ticks, repeating
    do_reset(16'h0000);
    for (int k = 1; k <= 16; k++) begin
      int         i;
      logic [3:0] a;
      i = (k - 1) % 4;
      a = ~(4'b0001 << i);
      if (((k - 1) / 2) % 2 == 1) begin
        push(4'b1111, SB, 1'b1, "alarm blank");
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 3) push(4'b1111, SB, 1'b1, "alarm lead");
        else        push(a, S0, (i == 2) ? 1'b0 : 1'b1, "alarm show");
`else
        push(a, S0, (i == 2) ? 1'b0 : 1'b1, "alarm show");
`endif
      end
    end
    drain("alarm");

    // 05:30 leading digit
    do_reset(16'h0530);
    push(4'b1110, S0, 1'b1, "lz d0");
    push(4'b1101, S3, 1'b1, "lz d1");
    push(4'b1011, S5, 1'b0, "lz d2");
`ifdef LEADING_ZERO_BLANK_EN
    push(4'b1111, SB, 1'b1, "lz d3");
`else
    push(4'b0111, S0, 1'b1, "lz d3");
`endif
    drain("lz");

    // Asynchronous reset in the middle of a frame
    do_reset(16'h1234);
    push(4'b1110, S4, 1'b1, "ar d0");
    push(4'b1101, S3, 1'b1, "ar d1");
    push(4'b1011, S2, 1'b0, "ar d2");
    drain("ar a");
    total = total + 1;
    if (an !== 4'b1011) begin
      bad = bad + 1;
      $display("FAIL ar pre: got an=%b, want an=1011", an);
    end
    rst_n = 1'b0;
    #1;
    total = total + 1;
    if (an !== 4'b1111 || seg !== SB || dp !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL ar async: got an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1",
               an, seg, dp);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(4'b1110, S4, 1'b1, "ar restart d0");
    drain("ar b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_time_display.md
Name: bcd_time_display

Overview:
- Reader side of the packed MM:SS BCD time word produced by the up/down countdown counter.
- Takes the 16-bit BCD time, {min_tens, min_ones, sec_tens, sec_ones}, and time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Snapshots the word once per scan frame so a digit never tears mid-frame.
- Blanks the digits in a blink pattern while the time reads 00:00 (doomsday reached).

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range 1..2^20.
- BLINK_TICKS, 250, scan ticks per half blink period; legal range 1..2^16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_time  input  16  packed BCD time, [15:12] min tens ... [3:0] sec ones; may change on any cycle.
- an  output  4  digit enables, active-low; an[0] is the rightmost digit (sec ones).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; used as the MM:SS colon.

Behaviour:
- Reset (async, while rst_n=0):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Prescaler=0, digit index=3, snapshot=16'h0000, blink counter=0, blink_phase=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - "tick" asserts for one cycle when count==SCAN_DIV-1, then the count wraps to 0.
  - With SCAN_DIV=1, tick is high every cycle.
- Digit index: advances 3→0→1→2→3 on each tick. Since reset leaves it at 3, the first tick after reset is a frame start.
- Frame start (tick where the index wraps 3→0):
  - snapshot <= bcd_time.
  - Digit 0 for that tick decodes from bcd_time[3:0] directly.
  - All other slots decode from the snapshot.
  - bcd_time changes mid-frame are invisible until the next frame start.
- Outputs are registered and update only on a tick. For new index i:
  - an = all ones except bit i = 0.
  - seg = decode(nibble i).
  - dp = 0 only when i==2; otherwise 1.
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9: dash 0111111. No range checks on tens digits beyond this.
- Blink:
  - Blink counter increments on each tick. On reaching BLINK_TICKS-1 it wraps to 0 and blink_phase toggles.
  - Blink runs continuously, independent of the time value.
- Zero alarm:
  - Condition: the snapshot in effect for the slot equals 16'h0000. For digit 0 at frame start, that is the freshly loaded value.
  - If the condition holds and blink_phase==1, the tick drives an=4'b1111, seg=7'b1111111, dp=1.
  - The index still advances.
  - A non-zero snapshot never blanks.
- Latency: a bcd_time change appears on the display at the first frame start after it. Worst case is 4*SCAN_DIV cycles plus 1.
- Reset mid-operation: outputs blank immediately. The first tick after release starts a fresh frame at digit 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - When the index is 3 and the displayed nibble [15:12]==0, an=4'b1111 and seg=7'b1111111 for that slot. Example: 05:30 shows " 5:30".
  - Digits 0..2 are never blanked by this feature.
  - The zero-alarm blink still applies.
- Undefined: digit 3 always shows its value, including 0.

Test Plan (SCAN_DIV=4, BLINK_TICKS=2):
- Reset, then release with bcd_time=16'h1234:
  - During reset: an=1111, seg=1111111, dp=1.
  - First tick, 4 cycles after release: an=1110, seg=0011001 ("4").
  - Subsequent ticks: an=1101 seg=0110000; an=1011 seg=0100100 dp=0; an=0111 seg=1111001.
- Frame tearing: bcd_time=16'h0959, change to 16'h1000 during the digit 1 slot:
  - Digits 2 and 3 still show 9 and 0 for the rest of that frame.
  - The next frame shows 0,0,0,1.
- Invalid digit: bcd_time=16'h00A7 → the digit 1 slot shows seg=0111111, digit 0 shows seg=1111000.
- Zero alarm: bcd_time=16'h0000, run 16 ticks:
  - Groups of 2 ticks alternate between normal "0" slots (seg=1000000, one an bit low) and fully blanked outputs.
  - The index still advances through the blanked ticks.
- Async reset mid-frame: assert rst_n=0 between ticks while an=1011:
  - an=1111 within the same cycle, with no clock edge needed.
  - After release, the first tick drives an=1110.
- With LEADING_ZERO_BLANK_EN defined, bcd_time=16'h0530:
  - The digit 3 slot shows an=1111, seg=1111111.
  - The digit 2 slot shows seg=0010010 dp=0.
  - Undefined: the digit 3 slot shows an=0111, seg=1000000.
